// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for data-SRAM responses on loads, aligns/extends load
// data, and hands completed instructions to WB. Flushes on WB exception/ERET.
module mem_stage #(
  parameter int ES_BUS_WD = 111,
  parameter int WS_BUS_WD = 75
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 ms_allowin,
  input  logic                 es_to_ms_valid,
  input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
  input  logic                 ws_allowin,
  output logic                 ms_to_ws_valid,
  output logic [WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]          data_rdata,
  input  logic                 data_rvalid,
  input  logic                 ws_ex,
  input  logic                 ws_eret,
  output logic [4:0]           mem_dest,
  output logic [31:0]          mem_dest_data,
  output logic                 mem_fwd_ok,
  output logic                 ms_ex
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CANCEL} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ms_valid;
  logic [ES_BUS_WD-1:0] r_bus;
  logic [31:0]         r_rdata;
  logic                r_buf_vld;

  logic [2:0]  w_ex_code;
  logic        w_eret;
  logic        w_bd;
  logic        w_mem_re;
  logic [2:0]  w_ld_type;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu;
  logic [31:0] w_rt;
  logic [31:0] w_pc;

  assign {w_ex_code, w_eret, w_bd, w_mem_re, w_ld_type, w_gr_we,
          w_dest, w_alu, w_rt, w_pc} = r_bus;

  logic w_flush;
  logic w_is_load;
  logic w_in_load;
  logic w_ready_go;
  logic w_accept;

  assign w_flush   = ws_ex | ws_eret;
  assign w_is_load = w_mem_re & (w_ex_code == 3'd0);
  assign w_in_load = es_to_ms_bus[105] & (es_to_ms_bus[110:108] == 3'd0);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state    <= S_IDLE;
      r_ms_valid <= 1'b0;
      r_bus      <= '0;
      r_rdata    <= '0;
      r_buf_vld  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_flush)         r_ms_valid <= 1'b0;
      else if (ms_allowin) r_ms_valid <= es_to_ms_valid;
      if (w_accept) r_bus <= es_to_ms_bus;
      if (w_accept) begin
        r_buf_vld <= 1'b0;
      end else if (r_state == S_WAIT && data_rvalid) begin
        r_buf_vld <= 1'b1;
        r_rdata   <= data_rdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned
    // (which would infer a latch).
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_in_load) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (data_rvalid)  w_state_nxt = (w_accept && w_in_load) ? S_WAIT : S_IDLE;
        else if (w_flush) w_state_nxt = S_CANCEL;
      end
      S_CANCEL: if (data_rvalid) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; a flush blocks both acceptance and handoff
  always_comb begin
    w_ready_go     = r_ms_valid & (!w_is_load | r_buf_vld |
                                   (r_state == S_WAIT && data_rvalid));
    ms_allowin     = (r_state != S_CANCEL) & (!r_ms_valid | (w_ready_go & ws_allowin));
    w_accept       = es_to_ms_valid & ms_allowin & !w_flush;
    ms_to_ws_valid = w_ready_go & !w_flush;
  end

  // Load data is bypassed from the SRAM in its arrival cycle, else taken from the buffer
  logic [31:0] w_word;
  logic [1:0]  w_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_final;

  assign w_word = r_buf_vld ? r_rdata : data_rdata;
  assign w_addr = w_alu[1:0];
  assign w_byte = w_word[{w_addr, 3'b000} +: 8];
  assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_final = w_alu;
    if (w_is_load) begin
      case (w_ld_type)
        3'd1: w_final = {{24{w_byte[7]}}, w_byte};
        3'd2: w_final = {24'd0, w_byte};
        3'd3: w_final = {{16{w_half[15]}}, w_half};
        3'd4: w_final = {16'd0, w_half};
        3'd5: begin
          case (w_addr)
            2'd0:    w_final = {w_word[7:0],  w_rt[23:0]};
            2'd1:    w_final = {w_word[15:0], w_rt[15:0]};
            2'd2:    w_final = {w_word[23:0], w_rt[7:0]};
            default: w_final = w_word;
          endcase
        end
        3'd6: begin
          case (w_addr)
            2'd0:    w_final = w_word;
            2'd1:    w_final = {w_rt[31:24], w_word[31:8]};
            2'd2:    w_final = {w_rt[31:16], w_word[31:16]};
            default: w_final = {w_rt[31:8],  w_word[31:24]};
          endcase
        end
        default: w_final = w_word;
      endcase
    end
  end

  assign ms_to_ws_bus  = {w_ex_code, w_eret, w_bd, w_gr_we, w_dest, w_final, w_pc};
  assign mem_dest      = (r_ms_valid && w_gr_we) ? w_dest : 5'd0;
  assign mem_dest_data = w_final;
  assign mem_fwd_ok    = w_ready_go;
  assign ms_ex         = r_ms_valid & ((w_ex_code != 3'd0) | w_eret);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized stream
// checked against a transaction-level model of load alignment and WB ordering.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [110:0] es_to_ms_bus;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [74:0]  ms_to_ws_bus;
  logic [31:0]  data_rdata;
  logic         data_rvalid;
  logic         ws_ex;
  logic         ws_eret;
  logic [4:0]   mem_dest;
  logic [31:0]  mem_dest_data;
  logic         mem_fwd_ok;
  logic         ms_ex;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .data_rdata(data_rdata),
    .data_rvalid(data_rvalid), .ws_ex(ws_ex), .ws_eret(ws_eret),
    .mem_dest(mem_dest), .mem_dest_data(mem_dest_data),
    .mem_fwd_ok(mem_fwd_ok), .ms_ex(ms_ex)
  );

  function automatic logic [110:0] mk(input logic [2:0] ex, input logic eret, input logic bd,
                                      input logic mem_re, input logic [2:0] ld, input logic gr_we,
                                      input logic [4:0] dest, input logic [31:0] alu,
                                      input logic [31:0] rt, input logic [31:0] pc);
    return {ex, eret, bd, mem_re, ld, gr_we, dest, alu, rt, pc};
  endfunction

  // Load result from byte-lane arithmetic
  function automatic logic [31:0] ref_load(input logic [2:0] ld, input int a,
                                           input logic [31:0] w, input logic [31:0] r);
    logic [31:0] b, h, m;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (ld)
      3'd1: return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      3'd2: return b;
      3'd3: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd4: return h;
      3'd5: begin
        m = (a == 3) ? 32'd0 : (32'hFFFFFFFF >> (8 * (a + 1)));
        return (w << (8 * (3 - a))) | (r & m);
      end
      3'd6: begin
        m = 32'hFFFFFFFF >> (8 * a);
        return (w >> (8 * a)) | (r & ~m);
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [74:0] exp_ws(input logic [110:0] b, input logic [31:0] w);
    logic [31:0] fr;
    if (b[105] && b[110:108] == 3'd0) fr = ref_load(b[104:102], int'(b[65:64]), w, b[63:32]);
    else                              fr = b[95:64];
    return {b[110:106], b[101:96], fr, b[31:0]};
  endfunction

  function automatic logic [110:0] rand_instr();
    logic [2:0]  ld;
    logic [2:0]  ex;
    logic [31:0] alu;
    ld  = 3'($urandom_range(0, 6));
    ex  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    alu = $urandom;
    if (ld == 3'd3 || ld == 3'd4) alu[0] = 1'b0;
    return mk(ex, ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), ld,
              1'($urandom), 5'($urandom), alu, $urandom, $urandom);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; es_to_ms_valid = 1'b0; ws_allowin = 1'b1;
    data_rvalid = 1'b0; ws_ex = 1'b0; ws_eret = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", ms_to_ws_valid); end
    total++; if (mem_dest !== 5'd0) begin bad++; $display("FAIL reset_dest got=%0h want=0", mem_dest); end
    total++; if (mem_fwd_ok !== 1'b0) begin bad++; $display("FAIL reset_fwd_ok got=%0h want=0", mem_fwd_ok); end
    total++; if (ms_ex !== 1'b0) begin bad++; $display("FAIL reset_ms_ex got=%0h want=0", ms_ex); end
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%0h want=1", ms_allowin); end
  endtask

  task automatic test_addu();
    logic [110:0] b;
    b = mk(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd3, 32'h5, 32'h0, 32'hBFC00000);
    @(negedge clk); es_to_ms_valid = 1'b1; es_to_ms_bus = b; #1;
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL addu_allowin got=%0h want=1", ms_allowin); end
    @(negedge clk); es_to_ms_valid = 1'b0; #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL addu_valid got=%0h want=1", ms_to_ws_valid); end
    total++; if (ms_to_ws_bus !== exp_ws(b, 32'h0)) begin bad++; $display("FAIL addu_bus got=%h want=%h", ms_to_ws_bus, exp_ws(b, 32'h0)); end
    total++; if (ms_to_ws_bus[63:32] !== 32'h5) begin bad++; $display("FAIL addu_result got=%h want=00000005", ms_to_ws_bus[63:32]); end
    total++; if (mem_fwd_ok !== 1'b1) begin bad++; $display("FAIL addu_fwd_ok got=%0h want=1", mem_fwd_ok); end
    total++; if (mem_dest !== 5'd3) begin bad++; $display("FAIL addu_dest got=%0d want=3", mem_dest); end
    @(negedge clk); #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL addu_drained got=%0h want=0", ms_to_ws_valid); end
  endtask

  task automatic test_load(input string name, input logic [2:0] ld, input logic [1:0] a,
                           input logic [31:0] rt, input logic [31:0] w, input int delay,
                           input logic [31:0] want);
    logic [110:0] b;
    b = mk(3'd0, 1'b0, 1'b0, 1'b1, ld, 1'b1, 5'd7, {30'h00400000, a}, rt, 32'hBFC00100);
    @(negedge clk); es_to_ms_valid = 1'b1; es_to_ms_bus = b; #1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk); es_to_ms_valid = 1'b0; #1;
      total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL %s_wait_valid got=%0h want=0", name, ms_to_ws_valid); end
      total++; if (mem_fwd_ok !== 1'b0) begin bad++; $display("FAIL %s_wait_fwd got=%0h want=0", name, mem_fwd_ok); end
    end
    @(negedge clk); es_to_ms_valid = 1'b0; data_rvalid = 1'b1; data_rdata = w; #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%0h want=1", name, ms_to_ws_valid); end
    total++; if (ms_to_ws_bus[63:32] !== want) begin bad++; $display("FAIL %s_result got=%h want=%h", name, ms_to_ws_bus[63:32], want); end
    total++; if (ms_to_ws_bus[63:32] !== ref_load(ld, int'(a), w, rt)) begin bad++; $display("FAIL %s_model got=%h want=%h", name, ms_to_ws_bus[63:32], ref_load(ld, int'(a), w, rt)); end
    total++; if (mem_fwd_ok !== 1'b1) begin bad++; $display("FAIL %s_fwd got=%0h want=1", name, mem_fwd_ok); end
    @(negedge clk); data_rvalid = 1'b0; #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL %s_once got=%0h want=0", name, ms_to_ws_valid); end
  endtask

  task automatic test_cancel();
    @(negedge clk); es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 5'd2, 32'h100, 32'h0, 32'h200); #1;
    @(negedge clk); es_to_ms_valid = 1'b0; ws_eret = 1'b1; #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL cancel_flush_valid got=%0h want=0", ms_to_ws_valid); end
    @(negedge clk); ws_eret = 1'b0; #1;
    total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL cancel_allowin got=%0h want=0", ms_allowin); end
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL cancel_valid got=%0h want=0", ms_to_ws_valid); end
    @(negedge clk); data_rvalid = 1'b1; data_rdata = 32'hDEADBEEF; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd9, 32'h1234, 32'h0, 32'h204); #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL cancel_discard got=%0h want=0", ms_to_ws_valid); end
    total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL cancel_rvalid_allowin got=%0h want=0", ms_allowin); end
    @(negedge clk); data_rvalid = 1'b0; #1;
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL cancel_resume_allowin got=%0h want=1", ms_allowin); end
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL cancel_empty got=%0h want=0", ms_to_ws_valid); end
    @(negedge clk); es_to_ms_valid = 1'b0; #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL cancel_next_valid got=%0h want=1", ms_to_ws_valid); end
    total++; if (ms_to_ws_bus[63:32] !== 32'h1234) begin bad++; $display("FAIL cancel_next_result got=%h want=00001234", ms_to_ws_bus[63:32]); end
    @(negedge clk); #1;
  endtask

  task automatic test_buffered();
    int hands = 0;
    @(negedge clk); ws_allowin = 1'b0; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 5'd4, 32'h300, 32'h0, 32'h300); #1;
    @(negedge clk); es_to_ms_valid = 1'b0; data_rvalid = 1'b1; data_rdata = 32'hCAFEF00D; #1;
    total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL buf_rvalid_allowin got=%0h want=0", ms_allowin); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); data_rvalid = 1'b0; data_rdata = 32'h0; #1;
      total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL buf_hold_allowin got=%0h want=0", ms_allowin); end
      total++; if (ms_to_ws_bus[63:32] !== 32'hCAFEF00D) begin bad++; $display("FAIL buf_hold_data got=%h want=cafef00d", ms_to_ws_bus[63:32]); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ws_allowin = 1'b1; #1;
      if (ms_to_ws_valid && ws_allowin) begin
        hands++;
        total++; if (ms_to_ws_bus[63:32] !== 32'hCAFEF00D) begin bad++; $display("FAIL buf_out_data got=%h want=cafef00d", ms_to_ws_bus[63:32]); end
      end
    end
    total++; if (hands != 1) begin bad++; $display("FAIL buf_handoff_count got=%0d want=1", hands); end
  endtask

  task automatic test_syscall();
    logic [110:0] b;
    b = mk(3'd3, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd4, 32'h44, 32'h0, 32'h400);
    @(negedge clk); es_to_ms_valid = 1'b1; es_to_ms_bus = b; #1;
    @(negedge clk); es_to_ms_valid = 1'b0; #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL sys_valid got=%0h want=1", ms_to_ws_valid); end
    total++; if (ms_ex !== 1'b1) begin bad++; $display("FAIL sys_ms_ex got=%0h want=1", ms_ex); end
    total++; if (ms_to_ws_bus !== exp_ws(b, 32'h0)) begin bad++; $display("FAIL sys_bus got=%h want=%h", ms_to_ws_bus, exp_ws(b, 32'h0)); end
    total++; if (mem_dest !== 5'd0) begin bad++; $display("FAIL sys_dest got=%0d want=0", mem_dest); end
    @(negedge clk); #1;
    total++; if (ms_ex !== 1'b0) begin bad++; $display("FAIL sys_ms_ex_clear got=%0h want=0", ms_ex); end
  endtask

  task automatic test_flush();
    @(negedge clk); ws_allowin = 1'b0; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd5, 32'h55, 32'h0, 32'h500); #1;
    @(negedge clk); ws_ex = 1'b1;
    es_to_ms_bus = mk(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd6, 32'h66, 32'h0, 32'h504); #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h want=0", ms_to_ws_valid); end
    @(negedge clk); ws_ex = 1'b0; es_to_ms_valid = 1'b0; #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0h want=0", ms_to_ws_valid); end
    total++; if (mem_dest !== 5'd0) begin bad++; $display("FAIL flush_dest got=%0d want=0", mem_dest); end
    ws_allowin = 1'b1;
  endtask

  task automatic test_random();
    logic [74:0] q[$];
    logic [74:0] exp;
    logic [31:0] w;
    logic [31:0] pend_w = 32'h0;
    bit          pending = 1'b0;
    bit          accepted = 1'b0;
    int          cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (accepted) es_to_ms_valid = 1'b0;
      accepted    = 1'b0;
      data_rvalid = pending && cnt == 0;
      data_rdata  = data_rvalid ? pend_w : $urandom;
      if (pending && cnt > 0) cnt--;
      ws_allowin  = (cyc >= 540) || ($urandom_range(0, 3) != 0);
      if (!es_to_ms_valid && cyc < 540 && $urandom_range(0, 1) == 1) begin
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = rand_instr();
      end
      #1;
      if (data_rvalid) pending = 1'b0;
      if (ms_to_ws_valid && ws_allowin) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_unexpected got=%h want=none", ms_to_ws_bus);
        end else begin
          exp = q.pop_front();
          if (ms_to_ws_bus !== exp) begin bad++; $display("FAIL rand_bus cyc=%0d got=%h want=%h", cyc, ms_to_ws_bus, exp); end
        end
      end
      if (es_to_ms_valid && ms_allowin) begin
        accepted = 1'b1;
        w = $urandom;
        q.push_back(exp_ws(es_to_ms_bus, w));
        if (es_to_ms_bus[105] && es_to_ms_bus[110:108] == 3'd0) begin
          pending = 1'b1; pend_w = w; cnt = $urandom_range(0, 3);
        end
      end
    end
    total++; if (q.size() != 0 || pending) begin bad++; $display("FAIL rand_drain got=%0d want=0", q.size()); end
    @(negedge clk); es_to_ms_valid = 1'b0; data_rvalid = 1'b0; ws_allowin = 1'b1;
  endtask

  initial begin
    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    data_rdata = 32'h0; data_rvalid = 1'b0; ws_ex = 1'b0; ws_eret = 1'b0;
    test_reset();
    test_addu();
    test_load("lb",  3'd1, 2'd3, 32'h0, 32'h80FF0011, 1, 32'hFFFFFF80);
    test_load("lbu", 3'd2, 2'd3, 32'h0, 32'h80FF0011, 1, 32'h00000080);
    test_load("lwl", 3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344, 0, 32'h3344CCDD);
    test_load("lwr", 3'd6, 2'd2, 32'hAABBCCDD, 32'h11223344, 2, 32'hAABB1122);
    test_load("lh",  3'd3, 2'd2, 32'h0, 32'h9ABC1234, 1, 32'hFFFF9ABC);
    test_load("lhu", 3'd4, 2'd2, 32'h0, 32'h9ABC1234, 0, 32'h00009ABC);
    test_cancel();
    test_buffered();
    test_syscall();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
